fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the decode stage.
- Holds the program counter and a word-addressed instruction memory, and computes PC+4.
- Drives the IF/ID pipeline register (instructd, pcd, pc4d) consumed by decode.
- Accepts hazard-unit stall/flush and execute-stage branch/jump redirects.

---
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RISC-V instruction-fetch stage: PC register, word-addressed instruction memory and the IF/ID register.
// One edge from pcF to IF/ID; stallF/stallD hold state, flushD inserts a bubble, and pcsrcE redirects the PC.
module fetch_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stallF,
    input  logic                          stallD,
    input  logic                          flushD,
    input  logic                          pcsrcE,
    input  logic [31:0]                   pctargetE,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   instructd,
    output logic [31:0]                   pcd,
    output logic [31:0]                   pc4d,
    output logic                          validd,
    output logic [31:0]                   pcF,
    output logic [31:0]                   fetch_count
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0]   r_imem [IMEM_DEPTH];
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic [31:0]   r_pcd;
    logic [31:0]   r_pc4d;
    logic          r_valid;
    logic [31:0]   r_fetch_count;

    logic [AW-1:0] w_idx;
    logic [31:0]   w_instr;
    logic [31:0]   w_pc4;
    logic          w_load;

    // Word index ignores byte offset and upper PC bits, so fetches wrap around the memory.
    assign w_idx   = r_pc[AW+1:2];
    assign w_instr = r_imem[w_idx];
    assign w_pc4   = r_pc + 32'd4;
    assign w_load  = !flushD && !stallD;

    // Program load is independent of reset so code can be written while the core is held.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (pcsrcE) begin
            r_pc <= pctargetE;
        end else if (!stallF) begin
            r_pc <= w_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_instr       <= NOP_INSTR;
            r_pcd         <= 32'd0;
            r_pc4d        <= 32'd0;
            r_valid       <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (flushD) begin
            r_instr <= NOP_INSTR;
            r_pcd   <= 32'd0;
            r_pc4d  <= 32'd0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_instr       <= w_instr;
            r_pcd         <= r_pc;
            r_pc4d        <= w_pc4;
            r_valid       <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign instructd   = r_instr;
    assign pcd         = r_pcd;
    assign pc4d        = r_pc4d;
    assign validd      = r_valid;
    assign pcF         = r_pc;
    assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a cycle-level reference model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst, stallF, stallD, flushD, pcsrcE, imem_we;
    logic [31:0] pctargetE, imem_wdata;
    logic [7:0]  imem_waddr;
    logic [31:0] instructd, pcd, pc4d, pcF, fetch_count;
    logic        validd;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_cnt;
    logic        m_vld;

    fetch_stage #(.IMEM_DEPTH(256), .RESET_PC(32'h0), .NOP_INSTR(32'h13)) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .pcsrcE(pcsrcE), .pctargetE(pctargetE), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .instructd(instructd), .pcd(pcd), .pc4d(pc4d), .validd(validd),
        .pcF(pcF), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_edge();
        logic [31:0] old_pc;
        old_pc = m_pc;
        if (!rst) begin
            m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_vld = 0; m_cnt = 0;
        end else begin
            if (flushD) begin
                m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_vld = 0;
            end else if (!stallD) begin
                m_instr = m_mem[(old_pc / 4) % 256];
                m_pcd   = old_pc;
                m_pc4d  = old_pc + 4;
                m_vld   = 1;
                m_cnt   = m_cnt + 1;
            end
            if (pcsrcE)       m_pc = pctargetE;
            else if (!stallF) m_pc = old_pc + 4;
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("pcF", pcF, m_pc);
        chk("instructd", instructd, m_instr);
        chk("pcd", pcd, m_pcd);
        chk("pc4d", pc4d, m_pc4d);
        chk("validd", {31'd0, validd}, {31'd0, m_vld});
        chk("fetch_count", fetch_count, m_cnt);
    endtask

    task automatic idle();
        rst = 1; stallF = 0; stallD = 0; flushD = 0; pcsrcE = 0; pctargetE = 0;
        imem_we = 0; imem_waddr = 0; imem_wdata = 0;
    endtask

    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'hx;
        m_pc = 32'hx; m_instr = 32'hx; m_pcd = 32'hx; m_pc4d = 32'hx; m_vld = 1'bx; m_cnt = 32'hx;

        // Program load under reset: random background, then the known words.
        idle();
        rst = 0;
        imem_we = 1;
        for (int i = 0; i < 256; i++) begin
            imem_waddr = 8'(i); imem_wdata = $urandom;
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            imem_waddr = 8'(i); imem_wdata = prog[i];
            cyc();
        end
        imem_waddr = 8'd16; imem_wdata = 32'h04000513;
        cyc();
        chk("reset_pcF", pcF, 32'h0);
        chk("reset_instr", instructd, 32'h13);
        chk("reset_valid", {31'd0, validd}, 32'd0);
        chk("reset_count", fetch_count, 32'd0);

        // Straight-line fetch
        idle();
        cyc(); chk("seq0_instr", instructd, prog[0]); chk("seq0_pcd", pcd, 32'h0);
        chk("seq0_valid", {31'd0, validd}, 32'd1);
        cyc(); chk("seq1_instr", instructd, prog[1]); chk("seq1_pcd", pcd, 32'h4);
        cyc(); chk("seq2_instr", instructd, prog[2]); chk("seq2_pcd", pcd, 32'h8);
        chk("seq2_pc4d", pc4d, 32'hC); chk("seq_count", fetch_count, 32'd3);
        cyc(); chk("pc_at_10", pcF, 32'h10);

        // Mid-run reset for 3 cycles
        rst = 0;
        repeat (3) cyc();
        chk("mrst_pcF", pcF, 32'h0); chk("mrst_instr", instructd, 32'h13);
        chk("mrst_pcd", pcd, 32'h0); chk("mrst_count", fetch_count, 32'd0);
        rst = 1;
        cyc(); chk("post_rst_instr", instructd, prog[0]);
        cyc(); chk("pre_stall_pcF", pcF, 32'h8);

        // Stall both stages
        stallF = 1; stallD = 1;
        repeat (2) cyc();
        chk("stall_pcF", pcF, 32'h8); chk("stall_pcd", pcd, 32'h4);
        chk("stall_count", fetch_count, 32'd2);
        stallF = 0; stallD = 0;
        cyc(); chk("unstall_pcd0", pcd, 32'h8);
        cyc(); chk("unstall_pcd1", pcd, 32'hC);

        // Redirect with flush; redirect beats stallF
        pcsrcE = 1; pctargetE = 32'h40; flushD = 1; stallF = 1;
        cyc(); chk("redir_pcF", pcF, 32'h40); chk("redir_valid", {31'd0, validd}, 32'd0);
        chk("redir_instr", instructd, 32'h13);
        idle();
        cyc(); chk("tgt_pcd", pcd, 32'h40); chk("tgt_instr", instructd, 32'h04000513);

        // Flush wins over stallD
        flushD = 1; stallD = 1;
        cyc(); chk("flstall_valid", {31'd0, validd}, 32'd0); chk("flstall_count", fetch_count, 32'd5);
        idle();

        // Address wrap
        pcsrcE = 1; pctargetE = 32'h400; flushD = 1;
        cyc(); idle();
        cyc(); chk("wrap_instr", instructd, prog[0]); chk("wrap_pcd", pcd, 32'h400);
        pcsrcE = 1; pctargetE = 32'hFFFF_FFFC; flushD = 1;
        cyc(); idle();
        cyc(); chk("top_pcd", pcd, 32'hFFFF_FFFC); chk("top_pc4d", pc4d, 32'h0);
        chk("top_pcF", pcF, 32'h0);

        // Randomized traffic, including same-cycle read/write of the fetched word
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 49) != 0);
            stallF    = ($urandom_range(0, 3) == 0);
            stallD    = ($urandom_range(0, 3) == 0);
            flushD    = ($urandom_range(0, 5) == 0);
            pcsrcE    = ($urandom_range(0, 7) == 0);
            pctargetE = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3FC);
            imem_we   = ($urandom_range(0, 2) == 0);
            imem_waddr = ($urandom_range(0, 1) == 0) ? pcF[9:2] : 8'($urandom);
            imem_wdata = $urandom;
            cyc();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
